cpu_sequencer: RTL

Multi-cycle sequencer for the 32-bit ARM-style core. It owns the PC, steps each instruction through the FETCH, DECODE, EXEC, MEM and WB states, and runs a request/ready handshake on the single shared memory port. It drives the instruction-register, memory-data-register and register-file write strobes, and applies branches. It sits between the instruction decoder, whose outputs it consumes, and the memory, register file and ALU datapath, which it strobes.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/cpu_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared types and constants for the multi-cycle CPU control path.
//   seq_state_t  : sequencer state encoding
//   PC_STEP      : byte step to the next sequential instruction
//   BRANCH_BIAS  : ARM-style pipeline bias added to branch targets
package cpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } seq_state_t;

  localparam logic [31:0] PC_STEP     = 32'd4;
  localparam logic [31:0] BRANCH_BIAS = 32'd8;

endpackage

// File: rtl/cpu_sequencer.sv
// cpu_sequencer
// Multi-cycle instruction sequencer: owns the PC, walks each instruction
// through FETCH/DECODE/EXEC/MEM/WB and runs the req/ready handshake on the
// single shared memory port.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_FETCH  | instruction read at pc, waits for mem_ready
// S_DECODE | decode and register-file read, no strobes
// S_EXEC   | ALU cycle; branch/NOP retire here, else go to MEM or WB
// S_MEM    | data access at ALU address, waits for mem_ready
// S_WB     | register-file write, retire
// S_HALT   | memory timeout; all strobes off until reset
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   dec_mem_load/store         decoded LDR / STR
//   dec_jump_en, dec_jump_addr decoded branch and sign-extended word offset
//   dec_reg_write_enable       decoded register write
//   mem_ready                  memory completes the current request
//   mem_req, mem_we            memory request / write qualifier
//   mem_addr_sel               0: pc, 1: ALU result
//   ir_load, mdr_load          IR / MDR capture strobes
//   rf_we, rf_wdata_sel        register write strobe / 0: ALU, 1: MDR
//   pc                         current instruction address
//   retire, retired_count      completion pulse and wrapping count
//   halted                     sticky memory-timeout flag
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_mem_load,
  input  logic        dec_mem_store,
  input  logic        dec_jump_en,
  input  logic        dec_reg_write_enable,
  input  logic [31:0] dec_jump_addr,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_load,
  output logic        mdr_load,
  output logic        rf_we,
  output logic        rf_wdata_sel,
  output logic [31:0] pc,
  output logic        retire,
  output logic [31:0] retired_count,
  output logic        halted
);

  localparam logic [31:0] TIMEOUT_CNT = 32'(MEM_TIMEOUT);
  localparam logic        TIMEOUT_EN  = (MEM_TIMEOUT != 0);

  seq_state_t  state;
  logic [31:0] pc_q;
  logic [31:0] retired_q;
  logic [31:0] wait_q;
  // Operation kind latched in EXEC so MEM/WB outputs stay pure state decode.
  logic        op_store_q;
  logic        wb_load_q;

  logic        in_wait;
  logic        exec_retire;
  logic        timeout_hit;
  logic [31:0] pc_seq;
  logic [31:0] pc_jump;

  assign in_wait     = (state == S_FETCH) || (state == S_MEM);
  assign exec_retire = dec_jump_en ||
                       !(dec_mem_load || dec_mem_store || dec_reg_write_enable);
  assign timeout_hit = TIMEOUT_EN && in_wait && !mem_ready &&
                       ((wait_q + 32'd1) == TIMEOUT_CNT);
  assign pc_seq      = pc_q + PC_STEP;
  assign pc_jump     = pc_q + BRANCH_BIAS + (dec_jump_addr << 2);

  // Every strobe is forced low during reset so an aborted cycle has no effect.
  assign mem_req      = !rst && in_wait;
  assign mem_we       = !rst && (state == S_MEM) && op_store_q;
  assign mem_addr_sel = (state == S_MEM);
  assign ir_load      = !rst && (state == S_FETCH) && mem_ready;
  assign mdr_load     = !rst && (state == S_MEM) && mem_ready && !op_store_q;
  assign rf_we        = !rst && (state == S_WB);
  assign rf_wdata_sel = (state == S_WB) && wb_load_q;
  assign retire       = !rst && (((state == S_EXEC) && exec_retire) ||
                                 ((state == S_MEM) && mem_ready && op_store_q) ||
                                 (state == S_WB));
  assign halted        = (state == S_HALT);
  assign pc            = pc_q;
  assign retired_count = retired_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      pc_q       <= RESET_PC;
      retired_q  <= '0;
      wait_q     <= '0;
      op_store_q <= 1'b0;
      wb_load_q  <= 1'b0;
    end else begin
      if (retire) begin
        retired_q <= retired_q + 32'd1;
      end

      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            wait_q <= '0;
            state  <= S_DECODE;
          end else if (timeout_hit) begin
            state <= S_HALT;
          end else begin
            wait_q <= wait_q + 32'd1;
          end
        end

        S_DECODE: begin
          state <= S_EXEC;
        end

        S_EXEC: begin
          wait_q <= '0;
          if (dec_jump_en) begin
            pc_q  <= pc_jump;
            state <= S_FETCH;
          end else if (dec_mem_load || dec_mem_store) begin
            // Load wins when both are decoded.
            op_store_q <= !dec_mem_load;
            state      <= S_MEM;
          end else if (dec_reg_write_enable) begin
            wb_load_q <= 1'b0;
            state     <= S_WB;
          end else begin
            pc_q  <= pc_seq;
            state <= S_FETCH;
          end
        end

        S_MEM: begin
          if (mem_ready) begin
            wait_q <= '0;
            if (op_store_q) begin
              pc_q  <= pc_seq;
              state <= S_FETCH;
            end else begin
              wb_load_q <= 1'b1;
              state     <= S_WB;
            end
          end else if (timeout_hit) begin
            state <= S_HALT;
          end else begin
            wait_q <= wait_q + 32'd1;
          end
        end

        S_WB: begin
          wait_q <= '0;
          pc_q   <= pc_seq;
          state  <= S_FETCH;
        end

        S_HALT: begin
          state <= S_HALT;
        end

        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

endmodule
